gray_seq_monitor: RTL and testbench

GRAY_SEQ_MONITOR -- requirements
Module: gray_seq_monitor

---
 rtl/gray_seq_monitor.sv | 136 +++++++++++++
 tb/tb_gray_seq_monitor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gray_seq_monitor.sv
// Gray-code sequence monitor: classifies each valid sample as up/down step, hold or error,
// tracks lock on a run of up-steps. Define GRAY_SEQ_MONITOR_WRAP_CNT_EN to build wrap_count.
module gray_seq_monitor #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out,
    output logic             step_up,
    output logic             step_dn,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic             locked,
    output logic [15:0]      wrap_count
);

    typedef enum logic [1:0] {StUnlock, StAcq, StLock} state_e;

    state_e           r_state, w_state_nxt;
    logic [3:0]       r_run, w_run_nxt;
    logic [WIDTH-1:0] r_prev_gray, r_bin;
    logic             r_step_up, r_step_dn, r_err;
    logic [ERR_W-1:0] r_err_cnt;
    logic             r_locked;

    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_diff;
    logic             w_hold, w_one, w_seeded;
    logic             w_up, w_dn, w_err;
    logic [3:0]       w_run_inc;

    always_comb begin
        w_bin = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_bin[i] = ^(gray_in >> i);
        end
    end

    assign w_diff    = gray_in ^ r_prev_gray;
    assign w_hold    = (w_diff == '0);
    assign w_one     = !w_hold && ((w_diff & (w_diff - WIDTH'(1))) == '0);
    // The first-sample flag is the UNLOCK state itself.
    assign w_seeded  = (r_state != StUnlock);
    assign w_up      = in_valid && w_seeded && w_one && (w_bin == r_bin + WIDTH'(1));
    assign w_dn      = in_valid && w_seeded && w_one && (w_bin != r_bin + WIDTH'(1));
    assign w_err     = in_valid && w_seeded && !w_hold && !w_one;
    assign w_run_inc = r_run + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        if (in_valid) begin
            case (r_state)
                StUnlock: begin
                    w_state_nxt = StAcq;
                    w_run_nxt   = 4'd0;
                end
                StAcq: begin
                    if (w_up) begin
                        w_run_nxt = w_run_inc;
                        if (w_run_inc >= 4'(LOCK_CNT)) w_state_nxt = StLock;
                    end else if (w_dn || w_err) begin
                        w_run_nxt = 4'd0;
                    end
                end
                StLock: begin
                    if (w_dn || w_err) begin
                        w_state_nxt = StAcq;
                        w_run_nxt   = 4'd0;
                    end
                end
                default: begin
                    w_state_nxt = StUnlock;
                    w_run_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StUnlock;
            r_run       <= 4'd0;
            r_prev_gray <= '0;
            r_bin       <= '0;
            r_step_up   <= 1'b0;
            r_step_dn   <= 1'b0;
            r_err       <= 1'b0;
            r_err_cnt   <= '0;
            r_locked    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_run     <= w_run_nxt;
            r_step_up <= w_up;
            r_step_dn <= w_dn;
            r_err     <= w_err;
            r_locked  <= (w_state_nxt == StLock);
            if (in_valid) begin
                r_prev_gray <= gray_in;
                r_bin       <= w_bin;
            end
            if (w_err && (r_err_cnt != {ERR_W{1'b1}})) r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
    end

`ifdef GRAY_SEQ_MONITOR_WRAP_CNT_EN
    logic [15:0] r_wrap;
    logic        w_wrap_hit;

    assign w_wrap_hit = w_up && (r_bin == {WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrap <= 16'd0;
        end else if (w_wrap_hit) begin
            r_wrap <= r_wrap + 16'd1;
        end
    end

    assign wrap_count = r_wrap;
`else
    assign wrap_count = 16'd0;
`endif

    assign bin_out   = r_bin;
    assign step_up   = r_step_up;
    assign step_dn   = r_step_dn;
    assign err_pulse = r_err;
    assign err_count = r_err_cnt;
    assign locked    = r_locked;

endmodule

// File: tb/tb_gray_seq_monitor.sv
// Bench for gray_seq_monitor: directed scenarios then random samples, checked every cycle
// against an arithmetic reference model.
module tb_gray_seq_monitor;

    localparam int W    = 2;
    localparam int LCNT = 4;
    localparam int EW   = 8;
    localparam int M    = 1 << W;

    logic          clk = 1'b0;
    logic          reset, in_valid;
    logic [W-1:0]  gray_in;
    logic [W-1:0]  bin_out;
    logic          step_up, step_dn, err_pulse, locked;
    logic [EW-1:0] err_count;
    logic [15:0]   wrap_count;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit m_seeded;
    int m_prev, m_bin, m_up, m_dn, m_err, m_errcnt, m_mode, m_run, m_wrap;

    gray_seq_monitor #(.WIDTH(W), .LOCK_CNT(LCNT), .ERR_W(EW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .gray_in    (gray_in),
        .bin_out    (bin_out),
        .step_up    (step_up),
        .step_dn    (step_dn),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .locked     (locked),
        .wrap_count (wrap_count)
    );

    always #5 clk = ~clk;

    function automatic int enc(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int dec(input int g);
        for (int b = 0; b < M; b++) if (enc(b) == g) return b;
        return -1;
    endfunction

    function automatic int popc(input int v);
        int n = 0;
        for (int i = 0; i < 32; i++) n += (v >> i) & 1;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input bit v, input int g);
        int bn, n;
        m_up = 0; m_dn = 0; m_err = 0;
        if (r) begin
            m_seeded = 0; m_prev = 0; m_bin = 0; m_errcnt = 0;
            m_mode = 0; m_run = 0; m_wrap = 0;
        end else if (v) begin
            bn = dec(g);
            if (!m_seeded) begin
                m_seeded = 1; m_mode = 1; m_run = 0;
            end else begin
                n = popc(g ^ m_prev);
                if (n == 1) begin
                    if (bn == (m_bin + 1) % M) m_up = 1; else m_dn = 1;
                end else if (n >= 2) begin
                    m_err = 1;
                end
                if (m_err && m_errcnt < (1 << EW) - 1) m_errcnt++;
`ifdef GRAY_SEQ_MONITOR_WRAP_CNT_EN
                if (m_up && m_bin == M - 1) m_wrap = (m_wrap + 1) % 65536;
`endif
                if (m_mode == 1) begin
                    if (m_up) begin
                        m_run++;
                        if (m_run >= LCNT) m_mode = 2;
                    end else if (m_dn || m_err) begin
                        m_run = 0;
                    end
                end else if (m_mode == 2 && (m_dn || m_err)) begin
                    m_mode = 1; m_run = 0;
                end
            end
            m_bin = bn; m_prev = g;
        end
    endtask

    // One clock: drive at negedge, model the edge, compare at the next negedge.
    task automatic cyc(input bit r, input bit v, input int g);
        reset = r; in_valid = v; gray_in = W'(g);
        model(r, v, g);
        @(negedge clk);
        chk("bin_out", 32'(bin_out), 32'(m_bin));
        chk("step_up", 32'(step_up), 32'(m_up));
        chk("step_dn", 32'(step_dn), 32'(m_dn));
        chk("err_pulse", 32'(err_pulse), 32'(m_err));
        chk("err_count", 32'(err_count), 32'(m_errcnt));
        chk("locked", 32'(locked), 32'(m_mode == 2));
        chk("wrap_count", 32'(wrap_count), 32'(m_wrap));
    endtask

    initial begin
        int k, nb;
        bit r, v;
        reset = 1'b1; in_valid = 1'b0; gray_in = '0;

        // Power-up reset, two cycles
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("reset_locked", 32'(locked), 32'd0);

        // Up-count sequence 00,01,11,10,00 reaches lock
        cyc(0, 1, 0);
        chk("first_no_pulse", 32'(step_up | step_dn | err_pulse), 32'd0);
        cyc(0, 1, 1);
        cyc(0, 1, 3);
        cyc(0, 0, 1);
        chk("idle_no_pulse", 32'(step_up), 32'd0);
        cyc(0, 1, 2);
        chk("not_yet_locked", 32'(locked), 32'd0);
        cyc(0, 1, 0);
        chk("locked_after_5", 32'(locked), 32'd1);
        chk("wrap_bin0", 32'(bin_out), 32'd0);

        // Hold then illegal two-bit step drops lock
        cyc(0, 1, 0);
        chk("hold_keeps_lock", 32'(locked), 32'd1);
        cyc(0, 1, 3);
        chk("err_bin2", 32'(bin_out), 32'd2);
        chk("err_cnt1", 32'(err_count), 32'd1);
        chk("err_unlock", 32'(locked), 32'd0);

        // 11->00 illegal, then 00->10 is a down step
        cyc(0, 1, 0);
        cyc(0, 1, 2);
        chk("dn_pulse", 32'(step_dn), 32'd1);
        chk("dn_bin3", 32'(bin_out), 32'd3);

        // 300 illegal steps saturate the error counter
        for (int i = 0; i < 300; i++) cyc(0, 1, (i % 2 == 0) ? 1 : 2);
        chk("err_sat", 32'(err_count), 32'd255);

        // Three full up cycles after a fresh reset
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        for (int c = 0; c < 3; c++) begin
            cyc(0, 1, 1); cyc(0, 1, 3); cyc(0, 1, 2); cyc(0, 1, 0);
        end
`ifdef GRAY_SEQ_MONITOR_WRAP_CNT_EN
        chk("wrap3", 32'(wrap_count), 32'd3);
`else
        chk("wrap_off", 32'(wrap_count), 32'd0);
`endif
        chk("locked_before_rst", 32'(locked), 32'd1);

        // Reset wins over a simultaneous sample; next sample is reference only
        cyc(1, 1, 1);
        chk("rst_all_zero", 32'({bin_out, step_up, step_dn, err_pulse, err_count, locked}), 32'd0);
        cyc(0, 1, 3);
        chk("rst_ref_only", 32'(step_up | step_dn | err_pulse), 32'd0);
        chk("rst_ref_bin", 32'(bin_out), 32'd2);

        // Random traffic biased towards legal steps
        for (int i = 0; i < 2000; i++) begin
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 3) != 0);
            k = $urandom_range(0, 9);
            if (k < 6)      nb = (m_bin + 1) % M;
            else if (k < 7) nb = (m_bin + M - 1) % M;
            else if (k < 8) nb = m_bin;
            else            nb = $urandom_range(0, M - 1);
            cyc(r, v, enc(nb));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
